fpga_mmio_responder: RTL and testbench

FPGA_MMIO_RESPONDER -- requirements
Module: fpga_mmio_responder

---
 rtl/fpga_mmio_responder.sv | 184 ++++++++++++++++++
 tb/tb_fpga_mmio_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_mmio_responder.sv
// ============================================================================
// Module   : fpga_mmio_responder
// Purpose  : Memory-mapped mailbox shared by an FPGA master and a CPU master.
//            The FPGA loads two operands and an opcode, the CPU posts a
//            result, the FPGA collects it. CPU has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpga_mmio_responder (
  input  logic        clk,
  input  logic        nrst,
  // FPGA side
  input  logic        fpga_en,
  input  logic        fpga_write,
  input  logic [31:0] fpga_addr,
  input  logic [31:0] fpga_wdata,
  input  logic        fpga_clr_n,
  output logic [31:0] fpga_rdata,
  output logic        fpga_ack,
  // CPU side
  input  logic        cpu_en,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  // Status
  output logic        ops_ready,
  output logic        result_valid
);

  // Register map (decimal byte addresses)
  localparam logic [31:0] c_ADDR_NUM1   = 32'd220;
  localparam logic [31:0] c_ADDR_NUM2   = 32'd240;
  localparam logic [31:0] c_ADDR_OP     = 32'd260;
  localparam logic [31:0] c_ADDR_RESULT = 32'd280;
  localparam logic [31:0] c_ADDR_STATUS = 32'd300;

  // Storage and sticky flags
  logic [31:0] r_num1;
  logic [31:0] r_num2;
  logic [31:0] r_op;
  logic [31:0] r_result;
  logic        r_w1;
  logic        r_w2;
  logic        r_wop;
  logic        r_rv;

  // Registered access outputs
  logic [31:0] r_fpga_rdata;
  logic [31:0] r_cpu_rdata;
  logic        r_fpga_ack;
  logic        r_cpu_ack;

  // Set on the edge that acknowledges an FPGA read of RESULT, so that the
  // valid flag drops one cycle after the ack (the ack cycle still shows it).
  logic        r_res_rd_ack;

  logic        w_cpu_gnt;
  logic        w_fpga_gnt;
  logic        w_fpga_wr;
  logic        w_cpu_wr;
  logic        w_ops_ready;
  logic [31:0] w_fpga_rd;
  logic [31:0] w_cpu_rd;

  // Fixed-priority arbitration: CPU always wins a contended cycle
  assign w_cpu_gnt   = cpu_en;
  assign w_fpga_gnt  = fpga_en & ~cpu_en;
  assign w_fpga_wr   = w_fpga_gnt & fpga_write;
  assign w_cpu_wr    = w_cpu_gnt & cpu_write;
  assign w_ops_ready = r_w1 & r_w2 & r_wop;

  // FPGA read-data mux over current (pre-update) register contents
  always_comb begin
    w_fpga_rd = '0;
    case (fpga_addr)
      c_ADDR_NUM1:   w_fpga_rd = r_num1;
      c_ADDR_NUM2:   w_fpga_rd = r_num2;
      c_ADDR_OP:     w_fpga_rd = r_op;
      c_ADDR_RESULT: w_fpga_rd = r_result;
      c_ADDR_STATUS: w_fpga_rd = {30'b0, r_rv, w_ops_ready};
      default:       w_fpga_rd = '0;
    endcase
  end

  // CPU read-data mux over the same map
  always_comb begin
    w_cpu_rd = '0;
    case (cpu_addr)
      c_ADDR_NUM1:   w_cpu_rd = r_num1;
      c_ADDR_NUM2:   w_cpu_rd = r_num2;
      c_ADDR_OP:     w_cpu_rd = r_op;
      c_ADDR_RESULT: w_cpu_rd = r_result;
      c_ADDR_STATUS: w_cpu_rd = {30'b0, r_rv, w_ops_ready};
      default:       w_cpu_rd = '0;
    endcase
  end

  // Access acknowledge and read data, one cycle after the grant
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fpga_ack   <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_fpga_rdata <= '0;
      r_cpu_rdata  <= '0;
      r_res_rd_ack <= 1'b0;
    end else begin
      r_fpga_ack   <= w_fpga_gnt;
      r_cpu_ack    <= w_cpu_gnt;
      // Writes return zero; the side not granted keeps its last data
      if (w_fpga_gnt)
        r_fpga_rdata <= fpga_write ? 32'd0 : w_fpga_rd;
      if (w_cpu_gnt)
        r_cpu_rdata  <= cpu_write ? 32'd0 : w_cpu_rd;
      r_res_rd_ack <= w_fpga_gnt & ~fpga_write & fpga_clr_n &
                      (fpga_addr == c_ADDR_RESULT);
    end
  end

  // Register file and flag update; soft clear overrides every write
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_num1   <= '0;
      r_num2   <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_w1     <= 1'b0;
      r_w2     <= 1'b0;
      r_wop    <= 1'b0;
      r_rv     <= 1'b0;
    end else if (!fpga_clr_n) begin
      r_num1   <= '0;
      r_num2   <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_w1     <= 1'b0;
      r_w2     <= 1'b0;
      r_wop    <= 1'b0;
      r_rv     <= 1'b0;
    end else begin
      // Result consumed by the FPGA on the previous ack edge
      if (r_res_rd_ack)
        r_rv <= 1'b0;
      // New operands make any posted result stale
      if (w_fpga_wr) begin
        case (fpga_addr)
          c_ADDR_NUM1: begin
            r_num1 <= fpga_wdata;
            r_w1   <= 1'b1;
            r_rv   <= 1'b0;
          end
          c_ADDR_NUM2: begin
            r_num2 <= fpga_wdata;
            r_w2   <= 1'b1;
            r_rv   <= 1'b0;
          end
          c_ADDR_OP: begin
            r_op   <= fpga_wdata;
            r_wop  <= 1'b1;
            r_rv   <= 1'b0;
          end
          default: ;
        endcase
      end
      // A freshly posted result takes precedence over a pending consume
      if (w_cpu_wr && (cpu_addr == c_ADDR_RESULT)) begin
        r_result <= cpu_wdata;
        r_rv     <= 1'b1;
      end
    end
  end

  assign fpga_rdata   = r_fpga_rdata;
  assign fpga_ack     = r_fpga_ack;
  assign cpu_rdata    = r_cpu_rdata;
  assign cpu_ack      = r_cpu_ack;
  assign ops_ready    = w_ops_ready;
  assign result_valid = r_rv;

endmodule

`default_nettype wire

// File: tb/tb_fpga_mmio_responder.sv
// ============================================================================
// Module   : tb_fpga_mmio_responder
// Purpose  : Directed self-checking bench for fpga_mmio_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpga_mmio_responder;

  logic        clk;
  logic        nrst;
  logic        fpga_en;
  logic        fpga_write;
  logic [31:0] fpga_addr;
  logic [31:0] fpga_wdata;
  logic        fpga_clr_n;
  logic [31:0] fpga_rdata;
  logic        fpga_ack;
  logic        cpu_en;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        ops_ready;
  logic        result_valid;

  int n_vec = 0;
  int n_err = 0;

  fpga_mmio_responder dut (
    .clk          (clk),
    .nrst         (nrst),
    .fpga_en      (fpga_en),
    .fpga_write   (fpga_write),
    .fpga_addr    (fpga_addr),
    .fpga_wdata   (fpga_wdata),
    .fpga_clr_n   (fpga_clr_n),
    .fpga_rdata   (fpga_rdata),
    .fpga_ack     (fpga_ack),
    .cpu_en       (cpu_en),
    .cpu_write    (cpu_write),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .ops_ready    (ops_ready),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fpga_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    fpga_en    = 1'b1;
    fpga_write = wr;
    fpga_addr  = addr;
    fpga_wdata = data;
  endtask

  task automatic cpu_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cpu_en    = 1'b1;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = data;
  endtask

  initial begin
    nrst       = 1'b0;
    fpga_en    = 1'b0;
    fpga_write = 1'b0;
    fpga_addr  = '0;
    fpga_wdata = '0;
    fpga_clr_n = 1'b1;
    cpu_en     = 1'b0;
    cpu_write  = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;

    // ---- Reset state
    #3;
    chk("rst_fpga_ack",     {31'b0, fpga_ack},     32'd0);
    chk("rst_cpu_ack",      {31'b0, cpu_ack},      32'd0);
    chk("rst_fpga_rdata",   fpga_rdata,            32'd0);
    chk("rst_cpu_rdata",    cpu_rdata,             32'd0);
    chk("rst_ops_ready",    {31'b0, ops_ready},    32'd0);
    chk("rst_result_valid", {31'b0, result_valid}, 32'd0);
    tick();
    tick();
    nrst = 1'b1;
    tick();

    // ---- Operand loading: ops_ready only after the third write
    fpga_req(1'b1, 32'd220, 32'h12);
    tick();
    chk("ld_num1_ack", {31'b0, fpga_ack},  32'd1);
    chk("ld_num1_rdy", {31'b0, ops_ready}, 32'd0);
    fpga_req(1'b1, 32'd240, 32'h34);
    tick();
    chk("ld_num2_ack", {31'b0, fpga_ack},  32'd1);
    chk("ld_num2_rdy", {31'b0, ops_ready}, 32'd0);
    fpga_req(1'b1, 32'd260, 32'h2);
    tick();
    chk("ld_op_ack",   {31'b0, fpga_ack},  32'd1);
    chk("ld_op_rdy",   {31'b0, ops_ready}, 32'd1);
    fpga_req(1'b0, 32'd220, 32'h0);
    tick();
    chk("rd_num1", fpga_rdata, 32'h12);
    fpga_en = 1'b0;
    tick();
    chk("idle_no_ack", {31'b0, fpga_ack}, 32'd0);

    // ---- Result hand-off: valid survives the ack cycle, drops after
    cpu_req(1'b1, 32'd280, 32'h46);
    tick();
    chk("cpu_wr_res_ack", {31'b0, cpu_ack},      32'd1);
    chk("cpu_wr_res_rv",  {31'b0, result_valid}, 32'd1);
    cpu_en = 1'b0;
    fpga_req(1'b0, 32'd280, 32'h0);
    tick();
    chk("rd_res_ack",   {31'b0, fpga_ack},     32'd1);
    chk("rd_res_data",  fpga_rdata,            32'h46);
    chk("rd_res_rv_on", {31'b0, result_valid}, 32'd1);
    fpga_en = 1'b0;
    tick();
    chk("rd_res_rv_off", {31'b0, result_valid}, 32'd0);

    // ---- Operand rewrite invalidates a posted result
    cpu_req(1'b1, 32'd280, 32'h55);
    tick();
    chk("repost_rv", {31'b0, result_valid}, 32'd1);
    cpu_en = 1'b0;
    fpga_req(1'b1, 32'd220, 32'h77);
    tick();
    chk("rewrite_rv_clr", {31'b0, result_valid}, 32'd0);
    chk("rewrite_rdy",    {31'b0, ops_ready},    32'd1);
    fpga_req(1'b0, 32'd300, 32'h0);
    tick();
    chk("status_rdy_only", fpga_rdata, 32'h1);

    // ---- Contention: CPU served each held cycle, FPGA retried afterwards
    cpu_req(1'b0, 32'd220, 32'h0);
    fpga_req(1'b0, 32'd240, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cont_cpu_ack",    {31'b0, cpu_ack},  32'd1);
      chk("cont_cpu_rdata",  cpu_rdata,         32'h77);
      chk("cont_fpga_noack", {31'b0, fpga_ack}, 32'd0);
      chk("cont_fpga_hold",  fpga_rdata,        32'h1);
    end
    cpu_en = 1'b0;
    tick();
    chk("retry_fpga_ack",  {31'b0, fpga_ack}, 32'd1);
    chk("retry_fpga_data", fpga_rdata,        32'h34);
    chk("retry_cpu_noack", {31'b0, cpu_ack},  32'd0);
    chk("retry_cpu_hold",  cpu_rdata,         32'h77);
    fpga_en = 1'b0;

    // ---- Soft clear coinciding with a CPU result post
    cpu_req(1'b1, 32'd280, 32'h99);
    fpga_clr_n = 1'b0;
    tick();
    chk("clr_cpu_ack", {31'b0, cpu_ack},      32'd1);
    chk("clr_rv",      {31'b0, result_valid}, 32'd0);
    chk("clr_rdy",     {31'b0, ops_ready},    32'd0);
    fpga_clr_n = 1'b1;
    cpu_req(1'b0, 32'd220, 32'h0);
    tick();
    chk("clr_num1_zero", cpu_rdata, 32'h0);
    cpu_en = 1'b0;
    fpga_req(1'b0, 32'd280, 32'h0);
    tick();
    chk("clr_result_zero", fpga_rdata, 32'h0);
    fpga_req(1'b0, 32'd300, 32'h0);
    tick();
    chk("clr_status_zero", fpga_rdata, 32'h0);

    // ---- Unmapped / read-only addresses
    fpga_req(1'b1, 32'd220, 32'h1);
    tick();
    fpga_req(1'b1, 32'd240, 32'h2);
    tick();
    fpga_req(1'b1, 32'd260, 32'h3);
    tick();
    fpga_req(1'b0, 32'd320, 32'h0);
    tick();
    chk("rd_idle_ack",  {31'b0, fpga_ack}, 32'd1);
    chk("rd_idle_data", fpga_rdata,        32'h0);
    fpga_req(1'b0, 32'h1000, 32'h0);
    tick();
    chk("rd_unmap_ack",  {31'b0, fpga_ack}, 32'd1);
    chk("rd_unmap_data", fpga_rdata,        32'h0);
    fpga_req(1'b1, 32'd300, 32'hFFFF);
    tick();
    chk("wr_status_ack",  {31'b0, fpga_ack}, 32'd1);
    chk("wr_status_data", fpga_rdata,        32'h0);
    fpga_req(1'b1, 32'd280, 32'hAA);
    tick();
    chk("wr_res_fpga_ack", {31'b0, fpga_ack}, 32'd1);
    fpga_req(1'b0, 32'd300, 32'h0);
    tick();
    chk("status_unchanged", fpga_rdata, 32'h1);
    fpga_en = 1'b0;
    cpu_req(1'b0, 32'd280, 32'h0);
    tick();
    chk("fpga_res_wr_ignored", cpu_rdata, 32'h0);
    cpu_req(1'b1, 32'd220, 32'hBB);
    tick();
    chk("cpu_wr_num1_ack", {31'b0, cpu_ack}, 32'd1);
    cpu_en = 1'b0;
    fpga_req(1'b0, 32'd220, 32'h0);
    tick();
    chk("cpu_num1_wr_ignored", fpga_rdata, 32'h1);

    // ---- Asynchronous reset in the middle of a held access
    tick();
    chk("pre_rst_ack", {31'b0, fpga_ack}, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("async_rst_ack",   {31'b0, fpga_ack},  32'd0);
    chk("async_rst_rdata", fpga_rdata,         32'h0);
    chk("async_rst_rdy",   {31'b0, ops_ready}, 32'd0);
    tick();
    chk("in_rst_noack", {31'b0, fpga_ack}, 32'd0);
    #1;
    nrst = 1'b1;
    tick();
    chk("post_rst_ack",   {31'b0, fpga_ack}, 32'd1);
    chk("post_rst_rdata", fpga_rdata,        32'h0);
    fpga_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
